// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues one sequential fetch per cycle, and queues returned
// instructions with their sequential PC for decode. Optional macro FETCH_NOP_FILL_EN.
module fetch_queue_unit #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0040_0000,
    parameter logic [INST_W-1:0] NOP_INST = 32'h3400_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc_seq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   resp_pc_seq;
    logic              resp_pending;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [INST_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]   pcseq_mem [DEPTH];

    logic              fifo_empty;
    logic              head_valid;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    assign fifo_empty = (count == '0);
    assign head_valid = ~fifo_empty & ~redirect_valid;
    assign pop        = head_valid & out_ready;
    assign push       = resp_pending & ~redirect_valid;

    // Credit covers queued entries plus the response still on its way back, so a
    // push can never land on a full FIFO.
    assign occupancy  = {1'b0, count} + OCC_W'(resp_pending) - OCC_W'(pop);
    assign imem_req   = reset & ~redirect_valid & (occupancy < DEPTH_OCC);
    assign imem_addr  = pc;

`ifdef FETCH_NOP_FILL_EN
    // Empty queue presents a bubble; accepting it does not pop anything.
    assign out_valid  = ~redirect_valid;
`else
    assign out_valid  = head_valid;
`endif

    assign out_instr  = fifo_empty ? NOP_INST : instr_mem[rd_ptr];
    assign out_pc_seq = fifo_empty ? '0       : pcseq_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            resp_pc_seq  <= '0;
            resp_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else if (redirect_valid) begin
            pc           <= redirect_pc;
            resp_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            resp_pending <= imem_req;
            if (imem_req) begin
                pc          <= pc + PC_W'(4);
                resp_pc_seq <= pc + PC_W'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_data;
            pcseq_mem[wr_ptr] <= resp_pc_seq;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: memory returns ~addr, expected values are hand-derived.
// Expectations adapt to FETCH_NOP_FILL_EN for empty-queue cycles.
module tb_fetch_queue_unit;

    localparam logic [31:0] RST = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h3400_0000;
`ifdef FETCH_NOP_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc_seq;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req;

    fetch_queue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc_seq     (out_pc_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle latency, data tagged by address.
    always @(posedge clk) begin
        if (imem_req) imem_data <= ~imem_addr;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_at(input int k);
        return RST + 32'(4 * k);
    endfunction

    initial begin
        imem_data      = '0;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        n_req          = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req",   32'(imem_req),  32'd0);
        chk_eq("rst_addr",  imem_addr,      RST);
        chk_eq("rst_valid", 32'(out_valid), 32'(FILL));
        chk_eq("rst_instr", out_instr,      NOP);
        chk_eq("rst_pcseq", out_pc_seq,     32'd0);

        // Free-running fetch with decode always ready.
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_eq("run_addr", imem_addr,     pc_at(k));
            chk_eq("run_req",  32'(imem_req), 32'd1);
            if (k >= 2) begin
                chk_eq("run_valid", 32'(out_valid), 32'd1);
                chk_eq("run_pcseq", out_pc_seq,     pc_at(k - 1));
                chk_eq("run_instr", out_instr,      ~pc_at(k - 2));
            end else begin
                chk_eq("run_valid_empty", 32'(out_valid), 32'(FILL));
                chk_eq("run_instr_empty", out_instr,      NOP);
                chk_eq("run_pcseq_empty", out_pc_seq,     32'd0);
            end
            cyc();
        end

        // Asynchronous reset in the middle of streaming.
        reset = 1'b0;
        #1;
        chk_eq("mrst_valid", 32'(out_valid), 32'(FILL));
        chk_eq("mrst_req",   32'(imem_req),  32'd0);
        chk_eq("mrst_addr",  imem_addr,      RST);
        chk_eq("mrst_pcseq", out_pc_seq,     32'd0);
        cyc();

        // Stall from reset: credit allows exactly DEPTH requests.
        out_ready = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) n_req++;
            cyc();
        end
        #1;
        chk_eq("stall_reqs",  32'(n_req),     32'd4);
        chk_eq("stall_valid", 32'(out_valid), 32'd1);
        chk_eq("stall_req",   32'(imem_req),  32'd0);
        chk_eq("stall_head",  out_pc_seq,     pc_at(1));

        // Release: entries drain in order with no gap; fetch resumes same cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_eq("drain_valid", 32'(out_valid), 32'd1);
            chk_eq("drain_pcseq", out_pc_seq,     pc_at(i + 1));
            chk_eq("drain_instr", out_instr,      ~pc_at(i));
            if (i == 0) begin
                chk_eq("drain_addr", imem_addr,     pc_at(4));
                chk_eq("drain_req",  32'(imem_req), 32'd1);
            end
            cyc();
        end

        // Redirect with three queued entries and a response in flight.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        #1;
        chk_eq("redir_valid", 32'(out_valid), 32'd0);
        chk_eq("redir_req",   32'(imem_req),  32'd0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk_eq("redir1_addr",  imem_addr,      32'h0040_0100);
        chk_eq("redir1_req",   32'(imem_req),  32'd1);
        chk_eq("redir1_valid", 32'(out_valid), 32'(FILL));
        chk_eq("redir1_instr", out_instr,      NOP);
        cyc();
        #1;
        chk_eq("redir2_addr",  imem_addr,      32'h0040_0104);
        chk_eq("redir2_valid", 32'(out_valid), 32'(FILL));
        chk_eq("redir2_instr", out_instr,      NOP);
        cyc();
        #1;
        chk_eq("redir3_valid", 32'(out_valid), 32'd1);
        chk_eq("redir3_pcseq", out_pc_seq,     32'h0040_0104);
        chk_eq("redir3_instr", out_instr,      ~32'h0040_0100);
        cyc();

        // Fill the queue, then redirect while decode is ready.
        out_ready = 1'b0;
        repeat (6) cyc();
        #1;
        chk_eq("full_valid", 32'(out_valid), 32'd1);
        chk_eq("full_req",   32'(imem_req),  32'd0);
        chk_eq("full_head",  out_pc_seq,     32'h0040_0108);
        redirect_valid = 1'b1;
        out_ready      = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk_eq("rfull_valid", 32'(out_valid), 32'd0);
        chk_eq("rfull_req",   32'(imem_req),  32'd0);
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        chk_eq("rfull_empty", 32'(out_valid), 32'(FILL));
        chk_eq("rfull_pcseq", out_pc_seq,     32'd0);
        chk_eq("rfull_instr", out_instr,      NOP);
        chk_eq("rfull_addr",  imem_addr,      32'hFFFF_FFFC);
        chk_eq("rfull_req1",  32'(imem_req),  32'd1);
        cyc();
        #1;
        chk_eq("wrap_addr", imem_addr, 32'd0);
        cyc();
        out_ready = 1'b1;
        #1;
        chk_eq("wrap_valid", 32'(out_valid), 32'd1);
        chk_eq("wrap_pcseq", out_pc_seq,     32'd0);
        chk_eq("wrap_instr", out_instr,      32'h0000_0003);
        cyc();
        #1;
        chk_eq("wrap2_pcseq", out_pc_seq, 32'd4);
        chk_eq("wrap2_instr", out_instr,  32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised fetch stage that decouples PC generation from the decode stage. It owns the PC register, issues one sequential fetch per cycle to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions with their sequential PC in a DEPTH-entry FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect input (branch/jump target) flushes the FIFO and any in-flight fetch.

## Interface
- PC_W, 32, PC and address width
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h00400000, PC value after reset
- NOP_INST, 32'h34000000, bubble instruction (ori $zero,$zero,0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  fetch address (current PC)
- imem_data  in  INST_W  read data, valid exactly one cycle after imem_req
- redirect_valid  in  1  load redirect_pc and flush
- redirect_pc  in  PC_W  redirect target
- out_valid  out  1  out_instr/out_pc_seq valid
- out_ready  in  1  decode accepts entry
- out_instr  out  INST_W  head instruction
- out_pc_seq  out  PC_W  head instruction's PC + 4

## Operation
- State: pc, FIFO (rd/wr pointers, count of width clog2(DEPTH+1)), resp_pending (1 bit: request issued last cycle).
- pop = out_valid & out_ready & ~redirect_valid.
- imem_req = ~redirect_valid & (count + resp_pending − pop < DEPTH); imem_addr = pc.
- On imem_req: pc <= pc + 4 (mod 2^PC_W, wraps silently); resp_pending <= 1, else 0.
- When resp_pending: push {imem_data, issuing pc + 4} into FIFO. Credit rule guarantees push never meets full FIFO.
- Push and pop in same cycle: count unchanged, both pointers advance.
- Redirect (priority over everything): at the edge, pc <= redirect_pc, count <= 0, pointers reset, resp_pending <= 0; a response arriving in the redirect cycle is discarded; out_valid forced 0 in redirect cycle so no pop occurs.
- out_valid = (count ≠ 0) & ~redirect_valid; out_instr/out_pc_seq from FIFO head; no empty-FIFO bypass.
- Reset (async, any time, including mid-fetch): pc = RESET_PC, count = 0, pointers = 0, resp_pending = 0; outputs: imem_req = 1 once reset deasserts (0 while asserted), imem_addr = RESET_PC, out_valid = 0 (or per FETCH_NOP_FILL_EN), out_instr = NOP_INST, out_pc_seq = 0 when empty.

## Timing
- Fetch-to-output latency: request in cycle N, entry pushed at end of N+1, out_valid high in N+2.
- Redirect sampled at edge E: request for redirect_pc in the cycle after E, out_valid for target two cycles after E.
- Steady state with out_ready=1: one instruction per cycle for any DEPTH ≥ 2.
- With out_ready=0: requests stop once count + resp_pending = DEPTH; resume the cycle pop makes room.
- All outputs except imem_req and out_valid are registered-state derived; imem_req/out_valid combinationally depend on redirect_valid and out_ready.

## Configuration
- FETCH_NOP_FILL_EN defined: when FIFO empty and not in redirect cycle, out_valid = 1 with out_instr = NOP_INST, out_pc_seq = 0; accepting a fill NOP does not pop. Reproduces legacy bubble-injection behaviour.
- Undefined: empty FIFO gives out_valid = 0; out_instr = NOP_INST as idle value only.

## Test plan
- Reset release, out_ready=1, memory returns addr-tagged data -> imem_addr 0x00400000, 0x00400004, ...; first out_valid 2 cycles later with out_pc_seq 0x00400004, then one per cycle.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, count saturates at 4, no overwrite; release yields entries in order with no gap.
- Redirect to 0x00400100 while FIFO holds 3 and a response is in flight -> out_valid=0 that cycle, stale data dropped, next output out_pc_seq 0x00400104 two cycles later.
- Redirect and out_ready asserted with full FIFO, same cycle -> no pop recorded, FIFO empty next cycle, imem_addr = redirect target.
- Assert reset mid-stream -> pc 0x00400000, out_valid 0 immediately (asynchronous), refill restarts from RESET_PC.
- Build with FETCH_NOP_FILL_EN, redirect -> out_valid=1, out_instr 0x34000000 for 2 cycles, then target instruction.
